// File: rtl/blit_wrq.sv
// Blitter register write queue: buffers CPU/GPU register writes and issues them
// in order, holding back entries the blitter cannot take yet.
module blit_wrq #(
  parameter int unsigned DEPTH = 4,
  parameter logic [23:0] BASE  = 24'hF02200
) (
  input  logic                       sys_clk,
  input  logic                       resetl,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [7:0]                 req_addr,
  input  logic [31:0]                req_data,
  input  logic                       flush,
  input  logic                       blit_back,
  input  logic                       blit_idle,
  output logic [23:0]                gpu_addr,
  output logic [31:0]                gpu_dout,
  output logic                       gpu_memw,
  output logic                       bliten,
  output logic [$clog2(DEPTH):0]     qcount,
  output logic                       drop_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [5:0] CMD_WORD = 6'h0E;

  logic [5:0]    off_mem  [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic       push;
  logic       push_store;
  logic       push_drop;
  logic       head_stall;
  logic       pop;
  logic [5:0] head_off;

  assign req_ready  = resetl & ~flush & (qcount < FULL_CNT);
  assign push       = req_valid & req_ready;
  assign push_store = push & (req_addr < 8'hA0);
  assign push_drop  = push & (req_addr >= 8'hA0);

  // Back-end registers (0x40 and up) wait for the back end; CMD waits for idle.
  assign head_off   = off_mem[rd_ptr];
  assign head_stall = ((head_off[5:4] != 2'b00) & blit_back) |
                      ((head_off == CMD_WORD) & ~blit_idle);
  assign pop        = resetl & ~flush & (qcount != '0) & ~head_stall;

  always_ff @(posedge sys_clk) begin
    if (push_store) begin
      off_mem[wr_ptr]  <= req_addr[7:2];
      data_mem[wr_ptr] <= req_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      qcount   <= '0;
      gpu_memw <= 1'b0;
      bliten   <= 1'b0;
      gpu_addr <= BASE;
      gpu_dout <= 32'h0;
      drop_err <= 1'b0;
    end else begin
      gpu_memw <= pop;
      bliten   <= pop;
      if (push_drop) begin
        drop_err <= 1'b1;
      end
      if (pop) begin
        gpu_addr <= {BASE[23:8], head_off, 2'b00};
        gpu_dout <= data_mem[rd_ptr];
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        qcount <= '0;
      end else begin
        if (push_store) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        qcount <= qcount + CW'(push_store) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_blit_wrq.sv
// Bench for blit_wrq: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based reference model.
module tb_blit_wrq;

  localparam int unsigned DEPTH = 4;
  localparam logic [23:0] BASE  = 24'hF02200;

  logic        sys_clk;
  logic        resetl;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_addr;
  logic [31:0] req_data;
  logic        flush;
  logic        blit_back;
  logic        blit_idle;
  logic [23:0] gpu_addr;
  logic [31:0] gpu_dout;
  logic        gpu_memw;
  logic        bliten;
  logic [2:0]  qcount;
  logic        drop_err;

  blit_wrq #(.DEPTH(DEPTH), .BASE(BASE)) dut (
    .sys_clk   (sys_clk),
    .resetl    (resetl),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .flush     (flush),
    .blit_back (blit_back),
    .blit_idle (blit_idle),
    .gpu_addr  (gpu_addr),
    .gpu_dout  (gpu_dout),
    .gpu_memw  (gpu_memw),
    .bliten    (bliten),
    .qcount    (qcount),
    .drop_err  (drop_err)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  typedef struct {
    logic [7:0]  off;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic        m_memw;
  logic [23:0] m_addr;
  logic [31:0] m_dout;
  logic        m_err;
  int          n_checks;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: predict from the pre-edge inputs, then compare after the edge.
  task automatic step();
    ent_t h;
    bit   rdy;
    bit   stalled;
    #1;
    rdy = resetl && !flush && (mq.size() < DEPTH);
    check("req_ready", 32'(req_ready), 32'(rdy));
    if (!resetl) begin
      mq.delete();
      m_memw = 1'b0;
      m_addr = BASE;
      m_dout = 32'h0;
      m_err  = 1'b0;
    end else if (flush) begin
      mq.delete();
      m_memw = 1'b0;
    end else begin
      m_memw = 1'b0;
      if (mq.size() != 0) begin
        h = mq[0];
        stalled = (h.off >= 8'h40 && blit_back) || (h.off == 8'h38 && !blit_idle);
        if (!stalled) begin
          h = mq.pop_front();
          m_memw = 1'b1;
          m_addr = (BASE & 24'hFFFF00) | 24'(h.off);
          m_dout = h.data;
        end
      end
      if (req_valid && rdy) begin
        if (req_addr >= 8'hA0) m_err = 1'b1;
        else mq.push_back('{off: req_addr & 8'hFC, data: req_data});
      end
    end
    @(posedge sys_clk);
    #1;
    check("gpu_memw", 32'(gpu_memw), 32'(m_memw));
    check("bliten",   32'(bliten),   32'(m_memw));
    check("gpu_addr", 32'(gpu_addr), 32'(m_addr));
    check("gpu_dout", gpu_dout,      m_dout);
    check("qcount",   32'(qcount),   32'(mq.size()));
    check("drop_err", 32'(drop_err), 32'(m_err));
  endtask

  task automatic push_cyc(input logic [7:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    step();
    req_valid = 1'b0;
  endtask

  task automatic idle_cyc(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    resetl = 1'b0;
    idle_cyc(2);
    resetl = 1'b1;
  endtask

  initial begin
    int r;
    n_checks  = 0;
    n_fail    = 0;
    resetl    = 1'b0;
    req_valid = 1'b0;
    req_addr  = 8'h00;
    req_data  = 32'h0;
    flush     = 1'b0;
    blit_back = 1'b0;
    blit_idle = 1'b1;
    m_memw    = 1'b0;
    m_addr    = BASE;
    m_dout    = 32'h0;
    m_err     = 1'b0;

    do_reset();
    check("rst_addr", 32'(gpu_addr), 32'h00F02200);

    // Single write, two-cycle latency, one-cycle strobe.
    push_cyc(8'h04, 32'h11223344);
    idle_cyc(1);
    check("lat_memw", 32'(gpu_memw), 32'h1);
    check("lat_addr", 32'(gpu_addr), 32'h00F02204);
    idle_cyc(1);
    check("lat_width", 32'(gpu_memw), 32'h0);

    // Back-end busy blocks 0x40 and everything behind it.
    blit_back = 1'b1;
    push_cyc(8'h00, 32'hA0000000);
    push_cyc(8'h40, 32'hA0000040);
    push_cyc(8'h24, 32'hA0000024);
    idle_cyc(3);
    check("back_qcount", 32'(qcount), 32'h2);
    blit_back = 1'b0;
    idle_cyc(4);

    // CMD waits for idle and keeps order with the following entry.
    blit_idle = 1'b0;
    push_cyc(8'h38, 32'hC0DE0038);
    push_cyc(8'h3C, 32'hC0DE003C);
    idle_cyc(3);
    check("cmd_hold", 32'(qcount), 32'h2);
    blit_idle = 1'b1;
    idle_cyc(4);

    // Full queue refuses a held push until a pop frees a slot.
    blit_back = 1'b1;
    for (int i = 0; i < 4; i++) push_cyc(8'(8'h40 + 4 * i), 32'(i));
    check("full_qcount", 32'(qcount), 32'h4);
    req_valid = 1'b1;
    req_addr  = 8'h10;
    req_data  = 32'h5A5A5A5A;
    for (int i = 0; i < 3; i++) step();
    blit_back = 1'b0;
    step();
    step();
    req_valid = 1'b0;
    idle_cyc(6);

    // Out-of-range drop, then flush of three stalled entries.
    push_cyc(8'h9C, 32'h9C9C9C9C);
    push_cyc(8'hA0, 32'hDEADBEEF);
    idle_cyc(2);
    check("drop_sticky", 32'(drop_err), 32'h1);
    blit_back = 1'b1;
    for (int i = 0; i < 3; i++) push_cyc(8'h80, 32'(i + 100));
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_qcount", 32'(qcount), 32'h0);
    idle_cyc(2);

    // Reset while full with a strobe pending.
    for (int i = 0; i < 4; i++) push_cyc(8'h44, 32'(i + 200));
    blit_back = 1'b0;
    step();
    resetl = 1'b0;
    step();
    check("rst_mid_memw", 32'(gpu_memw), 32'h0);
    check("rst_mid_addr", 32'(gpu_addr), 32'h00F02200);
    resetl = 1'b1;
    idle_cyc(2);

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      resetl    = ($urandom_range(0, 299) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      req_valid = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0) blit_back = ~blit_back;
      if ($urandom_range(0, 7) == 0) blit_idle = ~blit_idle;
      r = int'($urandom_range(0, 9));
      if (r == 0)      req_addr = 8'($urandom_range(8'hA0, 8'hFF));
      else if (r < 3)  req_addr = 8'($urandom_range(8'h38, 8'h3F));
      else             req_addr = 8'($urandom_range(0, 8'h9F));
      req_data = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/blit_wrq.md
BLIT_WRQ -- requirements
Module: blit_wrq

Interface
REQ-001 Parameters SHALL be: DEPTH, 4, queue entries (power of two, 2..8); BASE, 24'hF02200, blitter register block byte base.
REQ-002 Ports SHALL be: sys_clk  in  1  sole clock, all state on rising edge.
REQ-003 resetl  in  1  reset, synchronous and active-low.
REQ-004 req_valid  in  1  CPU/GPU-side write request.
REQ-005 req_ready  out  1  queue can accept.
REQ-006 req_addr  in  8  register byte offset; bits [1:0] ignored.
REQ-007 req_data  in  32  register write data.
REQ-008 flush  in  1  discard all queued entries.
REQ-009 blit_back  in  1  blitter back-end busy; blocks offsets 0x40..0x9F.
REQ-010 blit_idle  in  1  blitter idle; gates CMD (0x38) writes.
REQ-011 gpu_addr  out  24  {BASE[23:8], offset[7:2], 2'b00}.
REQ-012 gpu_dout  out  32  write data.
REQ-013 gpu_memw  out  1  one-cycle write strobe.
REQ-014 bliten  out  1  blitter select; equals gpu_memw.
REQ-015 qcount  out  log2(DEPTH)+1  occupied entries.
REQ-016 drop_err  out  1  sticky: out-of-range offset seen.

Function
REQ-017 The queue SHALL be an in-order FIFO of {offset[7:2], data}; push occurs on an edge where req_valid & req_ready.
REQ-018 req_ready SHALL be 1 iff resetl=1, flush=0 and qcount<DEPTH; a pop in the same cycle SHALL NOT make a full queue ready.
REQ-019 A request with offset >= 0xA0 SHALL be accepted (handshake completes), not stored, and SHALL set drop_err; offset 0x9C SHALL be stored and issued normally.
REQ-020 The head entry SHALL be stalled when (offset[7:6]!=0 and blit_back=1) or (offset=0x38 and blit_idle=0); a stalled head SHALL block all later entries (no reordering).
REQ-021 On an edge where the queue is non-empty, the head is not stalled and flush=0, the head SHALL be popped and gpu_memw, bliten, gpu_addr, gpu_dout SHALL be registered from it, valid for exactly the following cycle.
REQ-022 Latency SHALL be: push at edge E into an empty, unstalled queue, pop at edge E+1, gpu_memw=1 in the cycle after E+1.
REQ-023 Throughput SHALL be one write per cycle; back-to-back entries produce consecutive gpu_memw cycles.
REQ-024 In cycles with gpu_memw=0, gpu_addr and gpu_dout SHALL hold their last values.
REQ-025 Simultaneous push and pop SHALL leave qcount unchanged; pointers SHALL wrap modulo DEPTH.
REQ-026 flush=1 SHALL on that edge clear qcount to 0, block any push, and force gpu_memw=0 for the next cycle; drop_err SHALL be unaffected.
REQ-027 Stall inputs SHALL be sampled on the pop edge only; a blit_back change while a strobe is already registered SHALL NOT cancel it.
REQ-028 drop_err SHALL clear only on reset.

Reset
REQ-029 On an edge with resetl=0: qcount=0, gpu_memw=0, bliten=0, gpu_addr=BASE, gpu_dout=0, drop_err=0, pointers=0.
REQ-030 req_ready SHALL be 0 while resetl=0.
REQ-031 A reset mid-operation SHALL discard all entries, and no strobe SHALL follow the reset edge.

Verification
REQ-032 Push 0x04/0x11223344 into an empty queue with blit_back=0 -> gpu_memw=1 two cycles later, gpu_addr=0xF02204, gpu_dout=0x11223344, one cycle wide.
REQ-033 With blit_back=1, push 0x00, 0x40, 0x24 -> only 0x00 is issued, then qcount=2; deassert blit_back -> 0x40 then 0x24 are issued on consecutive cycles.
REQ-034 With blit_idle=0, push 0x38 then 0x3C -> no strobe; raise blit_idle -> 0x38 is issued before 0x3C.
REQ-035 Fill 4 entries under stall -> req_ready=0 and qcount=4; a push held 3 cycles is not accepted until a pop occurs.
REQ-036 Push 0xA0 -> no strobe, drop_err=1; then flush with 3 entries queued -> qcount=0, no strobe, drop_err stays 1.
REQ-037 Assert resetl=0 while the queue is full and a strobe is pending -> after the reset edge gpu_memw=0, qcount=0, gpu_addr=0xF02200.
